// File: rtl/vga_fb_pkg.sv
// Shared definitions for the paged VGA framebuffer driver: default 640x480@60 timing, width helpers, pixel type.
// Definitions only: no latency and no flow control.
package vga_fb_pkg;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SCALE_LOG2 = 3;
    localparam int DEF_R_W        = 3;
    localparam int DEF_G_W        = 3;
    localparam int DEF_B_W        = 2;
    localparam int DEF_NUM_PAGES  = 2;

    typedef struct packed {
        logic [DEF_R_W-1:0] r;
        logic [DEF_G_W-1:0] g;
        logic [DEF_B_W-1:0] b;
    } pixel_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Never returns 0 so single-entry dimensions still get a 1-bit field.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider and raster counters producing active/sync flags, cell coordinates and the vblank-start strobe.
// Flags are combinational from the counter registers (stage 0); free-running, no backpressure.
module vga_timing_gen
    import vga_fb_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
    parameter int CA_W       = 7,
    parameter int RA_W       = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            tick_o,
    output logic            active_o,
    output logic            hs_raw_o,
    output logic            vs_raw_o,
    output logic            vblank_start_o,
    output logic [RA_W-1:0] row_o,
    output logic [CA_W-1:0] col_o
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HC_W    = clog2w(H_TOTAL);
    localparam int VC_W    = clog2w(V_TOTAL);
    localparam int DV_W    = clog2w(CLK_DIV);

    logic [DV_W-1:0] div_q, div_d;
    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic [VC_W-1:0] vcnt_q, vcnt_d;
    logic            tick;
    logic            h_last;

    assign tick   = (int'(div_q) == CLK_DIV - 1);
    assign h_last = (int'(hcnt_q) == H_TOTAL - 1);

    always_comb begin
        div_d  = tick ? '0 : div_q + DV_W'(1);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = (int'(vcnt_q) == V_TOTAL - 1) ? '0 : vcnt_q + VC_W'(1);
            end else begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign tick_o   = tick;
    assign active_o = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    assign hs_raw_o = (int'(hcnt_q) >= H_ACTIVE + H_FP) &&
                      (int'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs_raw_o = (int'(vcnt_q) >= V_ACTIVE + V_FP) &&
                      (int'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC);

    // Fires on the tick that moves the raster onto the first blank line.
    assign vblank_start_o = tick && h_last && (int'(vcnt_q) == V_ACTIVE - 1);

    assign row_o = vcnt_q[SCALE_LOG2 +: RA_W];
    assign col_o = hcnt_q[SCALE_LOG2 +: CA_W];

endmodule

// File: rtl/vga_fb_driver_param.sv
// Paged VGA framebuffer driver: MCU read/write port, raster scan-out with blanking, tear-free page flip at vblank.
// Video latency 2 pixel ticks (colour, HS, VS aligned); RD 1 CLK; no backpressure on either port.
module vga_fb_driver_param
    import vga_fb_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
    parameter int R_W        = DEF_R_W,
    parameter int G_W        = DEF_G_W,
    parameter int B_W        = DEF_B_W,
    parameter int NUM_PAGES  = DEF_NUM_PAGES,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    localparam int PIX_W     = R_W + G_W + B_W,
    localparam int PG_W      = clog2w(NUM_PAGES),
    localparam int CA_W      = clog2w(H_ACTIVE >> SCALE_LOG2),
    localparam int RA_W      = clog2w(V_ACTIVE >> SCALE_LOG2),
    localparam int AW        = PG_W + RA_W + CA_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [AW-1:0]    WA,
    input  logic [PIX_W-1:0] WD,
    input  logic             WE,
    output logic [PIX_W-1:0] RD,
    input  logic [PG_W-1:0]  PAGE_SEL,
    output logic [PG_W-1:0]  PAGE_ACT,
    output logic             FRAME_START,
    output logic [R_W-1:0]   ROUT,
    output logic [G_W-1:0]   GOUT,
    output logic [B_W-1:0]   BOUT,
    output logic             HS,
    output logic             VS
);

    localparam int COLS  = H_ACTIVE >> SCALE_LOG2;
    localparam int ROWS  = V_ACTIVE >> SCALE_LOG2;
    localparam int DEPTH = 1 << AW;

    logic            tick;
    logic            active;
    logic            hs_raw;
    logic            vs_raw;
    logic            vblank_start;
    logic [RA_W-1:0] disp_row;
    logic [CA_W-1:0] disp_col;

    vga_timing_gen #(
        .CLK_DIV    (CLK_DIV),
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .SCALE_LOG2 (SCALE_LOG2),
        .CA_W       (CA_W),
        .RA_W       (RA_W)
    ) u_timing (
        .clk_i          (CLK),
        .rst_ni         (RST_N),
        .tick_o         (tick),
        .active_o       (active),
        .hs_raw_o       (hs_raw),
        .vs_raw_o       (vs_raw),
        .vblank_start_o (vblank_start),
        .row_o          (disp_row),
        .col_o          (disp_col)
    );

    logic [PG_W-1:0] wa_page;
    logic [RA_W-1:0] wa_row;
    logic [CA_W-1:0] wa_col;
    logic            wa_ok;
    logic            sel_ok;

    assign {wa_page, wa_row, wa_col} = WA;
    assign wa_ok  = (int'(wa_page) < NUM_PAGES) && (int'(wa_row) < ROWS) && (int'(wa_col) < COLS);
    assign sel_ok = (int'(PAGE_SEL) < NUM_PAGES);

    // Address space is the sparse {page,row,col} concatenation; unused holes are never written.
    logic [PIX_W-1:0] mem_q [DEPTH];

    // Both read ports sample mem_q before this write lands, giving read-first behaviour.
    always_ff @(posedge CLK) begin
        if (WE && wa_ok) begin
            mem_q[WA] <= WD;
        end
    end

    logic [PG_W-1:0]  page_act_q, page_act_d;
    logic             frame_start_q, frame_start_d;
    logic [PIX_W-1:0] rd_q, rd_d;
    logic [PIX_W-1:0] pix_s1_q, pix_s1_d;
    logic             act_s1_q, act_s1_d;
    logic             hs_s1_q, hs_s1_d;
    logic             vs_s1_q, vs_s1_d;
    logic [PIX_W-1:0] pix_s2_q, pix_s2_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [AW-1:0]    disp_addr;

    assign disp_addr = {page_act_q, disp_row, disp_col};

    always_comb begin
        rd_d          = wa_ok ? mem_q[WA] : '0;
        page_act_d    = page_act_q;
        frame_start_d = 1'b0;
        pix_s1_d      = pix_s1_q;
        act_s1_d      = act_s1_q;
        hs_s1_d       = hs_s1_q;
        vs_s1_d       = vs_s1_q;
        pix_s2_d      = pix_s2_q;
        hs_d          = hs_q;
        vs_d          = vs_q;

        if (tick) begin
            pix_s1_d = mem_q[disp_addr];
            act_s1_d = active;
            hs_s1_d  = hs_raw;
            vs_s1_d  = vs_raw;
            pix_s2_d = act_s1_q ? pix_s1_q : '0;
            hs_d     = hs_s1_q ? HS_POL : ~HS_POL;
            vs_d     = vs_s1_q ? VS_POL : ~VS_POL;
        end

        // The last visible pixel has already been fetched, so switching here cannot tear.
        if (vblank_start) begin
            frame_start_d = 1'b1;
            if (sel_ok) begin
                page_act_d = PAGE_SEL;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_q          <= '0;
            page_act_q    <= '0;
            frame_start_q <= 1'b0;
            pix_s1_q      <= '0;
            act_s1_q      <= 1'b0;
            hs_s1_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            pix_s2_q      <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
        end else begin
            rd_q          <= rd_d;
            page_act_q    <= page_act_d;
            frame_start_q <= frame_start_d;
            pix_s1_q      <= pix_s1_d;
            act_s1_q      <= act_s1_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            pix_s2_q      <= pix_s2_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign RD                 = rd_q;
    assign PAGE_ACT           = page_act_q;
    assign FRAME_START        = frame_start_q;
    assign {ROUT, GOUT, BOUT} = pix_s2_q;
    assign HS                 = hs_q;
    assign VS                 = vs_q;

endmodule

// File: tb/tb_vga_fb_driver_param.sv
// Bench for the paged VGA framebuffer driver on a shrunk raster (88x48 total, 9x5 cells, 3 pages).
// A raster-position model predicts every output each CLK; literal checks pin alignment, sync and flip timing.
module tb_vga_fb_driver_param;
    import vga_fb_pkg::*;

    localparam int DIV  = 2;
    localparam int HA   = 72;
    localparam int HFP  = 4;
    localparam int HSY  = 8;
    localparam int HBP  = 4;
    localparam int VA   = 40;
    localparam int VFP  = 2;
    localparam int VSY  = 2;
    localparam int VBP  = 4;
    localparam int SC   = 3;
    localparam int NP   = 3;
    localparam int HT   = HA + HFP + HSY + HBP;
    localparam int VT   = VA + VFP + VSY + VBP;
    localparam int COLS = HA >> SC;
    localparam int ROWS = VA >> SC;
    localparam int PG_W = 2;
    localparam int RA_W = 3;
    localparam int CA_W = 4;
    localparam int AW   = PG_W + RA_W + CA_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   wa = '0;
    logic [7:0]      wd = '0;
    logic            we = 1'b0;
    logic [PG_W-1:0] page_sel = '0;
    logic [7:0]      rd;
    logic [PG_W-1:0] page_act;
    logic            frame_start;
    logic [2:0]      rout;
    logic [2:0]      gout;
    logic [1:0]      bout;
    logic            hs;
    logic            vs;

    always #5 clk = ~clk;

    vga_fb_driver_param #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SCALE_LOG2(SC),
        .R_W(3), .G_W(3), .B_W(2), .NUM_PAGES(NP), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .WA(wa), .WD(wd), .WE(we), .RD(rd),
        .PAGE_SEL(page_sel), .PAGE_ACT(page_act), .FRAME_START(frame_start),
        .ROUT(rout), .GOUT(gout), .BOUT(bout), .HS(hs), .VS(vs)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [AW-1:0] mk(input int pg, input int row, input int col);
        return {2'(pg), 3'(row), 4'(col)};
    endfunction

    // Model state: posedges since reset release, page shown, expected per-pixel-period outputs.
    int   ncyc = 0;
    int   m_page = 0;
    int   m_fs = 0;
    int   m_rd = 0;
    logic [7:0] shadow [NP][ROWS][COLS];
    int   exp_pix [int];
    bit   exp_hs [int];
    bit   exp_vs [int];

    always @(posedge clk) begin
        int pg, row, col, p, h, v;
        bit ok;
        pg  = int'(wa[8:7]);
        row = int'(wa[6:4]);
        col = int'(wa[3:0]);
        ok  = (pg < NP) && (row < ROWS) && (col < COLS);
        if (!rst_n) begin
            ncyc   = 0;
            m_page = 0;
            m_fs   = 0;
            m_rd   = 0;
            exp_pix.delete();
            exp_hs.delete();
            exp_vs.delete();
        end else begin
            m_fs = 0;
            if (ncyc % DIV == DIV - 1) begin
                p = ncyc / DIV;
                h = p % HT;
                v = (p / HT) % VT;
                exp_pix[p] = (h < HA && v < VA) ? int'(shadow[m_page][v >> SC][h >> SC]) : 0;
                exp_hs[p]  = (h >= HA + HFP) && (h < HA + HFP + HSY);
                exp_vs[p]  = (v >= VA + VFP) && (v < VA + VFP + VSY);
                if (h == HT - 1 && v == VA - 1) begin
                    m_fs = 1;
                    if (int'(page_sel) < NP) m_page = int'(page_sel);
                end
            end
            m_rd = ok ? int'(shadow[pg][row][col]) : 0;
            ncyc++;
        end
        if (we && ok) shadow[pg][row][col] = wd;
    end

    always @(negedge clk) begin
        int q, ep;
        bit eh, ev;
        pixel_t px;
        if (!rst_n) begin
            chk("rst_rgb", int'({rout, gout, bout}), 0);
            chk("rst_hs", int'(hs), 1);
            chk("rst_vs", int'(vs), 1);
            chk("rst_page_act", int'(page_act), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_rd", int'(rd), 0);
        end else begin
            q  = ncyc / DIV - 2;
            ep = exp_pix.exists(q) ? exp_pix[q] : 0;
            eh = exp_hs.exists(q) ? exp_hs[q] : 1'b0;
            ev = exp_vs.exists(q) ? exp_vs[q] : 1'b0;
            px = pixel_t'(ep[7:0]);
            chk("red", int'(rout), int'(px.r));
            chk("green", int'(gout), int'(px.g));
            chk("blue", int'(bout), int'(px.b));
            chk("hs", int'(hs), eh ? 0 : 1);
            chk("vs", int'(vs), ev ? 0 : 1);
            chk("page_act", int'(page_act), m_page);
            chk("frame_start", int'(frame_start), m_fs);
            chk("rd", int'(rd), m_rd);
        end
    end

    task automatic wait_int(input int k);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ncyc < k && guard < 20000);
        if (ncyc != k) begin
            checks++;
            failures++;
            $display("FAIL wait_interval actual=%0d required=%0d", ncyc, k);
        end
    endtask

    task automatic wr(input int pg, input int row, input int col, input int val);
        @(negedge clk);
        wa = mk(pg, row, col);
        wd = 8'(val);
        we = 1'b1;
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        chk("lit_rst_rgb", int'({rout, gout, bout}), 0);
        chk("lit_rst_hs", int'(hs), 1);
        chk("lit_rst_vs", int'(vs), 1);

        for (int pg = 0; pg < NP; pg++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    wr(pg, r, c, int'($urandom_range(0, 255)));
        wr(0, 0, 0, 'hE3);
        wr(0, 0, 1, 'h1C);
        wr(0, 1, 0, 'h03);
        wr(0, 2, 5, 'h2A);
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        wait_int(1);    chk("tick0_black", int'({rout, gout, bout}), 0);
        wait_int(3);    chk("tick1_black", int'({rout, gout, bout}), 0);
        wait_int(4);    chk("tick2_red", int'(rout), 7);
                        chk("tick2_green", int'(gout), 0);
                        chk("tick2_blue", int'(bout), 3);
        wait_int(19);   chk("tick9_cell0", int'({rout, gout, bout}), 'hE3);
        wait_int(20);   chk("tick10_green", int'(gout), 7);
                        chk("tick10_cell1", int'({rout, gout, bout}), 'h1C);
        wait_int(155);  chk("hs_before", int'(hs), 1);
        wait_int(156);  chk("hs_first", int'(hs), 0);
        wait_int(171);  chk("hs_last", int'(hs), 0);
        wait_int(172);  chk("hs_after", int'(hs), 1);
        cnt = 0;
        for (int k = 176; k < 176 + 2 * HT; k++) begin
            wait_int(k);
            if (!hs) cnt++;
        end
        chk("hs_width_clk", cnt, 2 * HSY);
        wait_int(1237); chk("row7_cell_row0", int'({rout, gout, bout}), 'hE3);
        wait_int(1413); chk("row8_cell_row1", int'({rout, gout, bout}), 'h03);

        wait_int(1760);
        wa = mk(1, 0, 0);
        wd = 8'h1C;
        we = 1'b1;
        page_sel = 2'd1;
        wait_int(1761);
        we = 1'b0;

        wait_int(1800);
        wa = mk(0, 0, 9);
        wd = 8'hFF;
        we = 1'b1;
        wait_int(1801); chk("rd_out_of_range", int'(rd), 0);
        wa = mk(0, 2, 5);
        we = 1'b0;
        wait_int(1802); chk("rd_before_write", int'(rd), 'h2A);
        wd = 8'h55;
        we = 1'b1;
        wait_int(1803); chk("rd_read_first", int'(rd), 'h2A);
        we = 1'b0;
        wait_int(1804); chk("rd_new_data", int'(rd), 'h55);

        wait_int(7039); chk("flip_pa_before", int'(page_act), 0);
                        chk("flip_fs_before", int'(frame_start), 0);
        wait_int(7040); chk("flip_pa_after", int'(page_act), 1);
                        chk("flip_fs_pulse", int'(frame_start), 1);
        wait_int(7041); chk("flip_fs_end", int'(frame_start), 0);
        wait_int(7395); chk("vs_before", int'(vs), 1);
        wait_int(7396); chk("vs_first", int'(vs), 0);
                        chk("vs_hs_aligned", int'(hs), 1);
        wait_int(8452); chk("page1_pixel0_green", int'(gout), 7);
                        chk("page1_pixel0", int'({rout, gout, bout}), 'h1C);

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            we = ($urandom_range(0, 3) == 0);
            wa = AW'($urandom);
            wd = 8'($urandom);
            if ($urandom_range(0, 799) == 0) page_sel = 2'($urandom_range(0, 3));
            if (i == 4000) begin
                we = 1'b0;
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst_rgb", int'({rout, gout, bout}), 0);
                chk("async_rst_hs", int'(hs), 1);
                chk("async_rst_vs", int'(vs), 1);
                chk("async_rst_page_act", int'(page_act), 0);
                chk("async_rst_fs", int'(frame_start), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        we = 1'b0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_driver_param.md
Name: vga_fb_driver_param

Overview:
Parametrised successor to the fixed 80x60 VGA framebuffer driver for the RAT MCU on Basys3. Contains an internal dual-port framebuffer with NUM_PAGES display pages and a write/read port for the MCU. It also has a parametrised VGA timing generator, a fixed-latency pixel pipeline with blanking, and tear-free page flipping at vertical blank.

Parameters:
CLK_DIV, 2, CLK cycles per pixel tick (2 gives 25 MHz from 50 MHz).
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch, in pixels.
H_SYNC, 96, horizontal sync width, in pixels.
H_BP, 48, horizontal back porch, in pixels.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch, in lines.
V_SYNC, 2, vertical sync width, in lines.
V_BP, 33, vertical back porch, in lines.
SCALE_LOG2, 3, log2 of the screen-pixel block edge per framebuffer cell (3 gives 80x60).
R_W, 3, red bits.
G_W, 3, green bits.
B_W, 2, blue bits. PIX_W = R_W+G_W+B_W.
NUM_PAGES, 2, framebuffer pages. PG_W = max(1, clog2(NUM_PAGES)).
HS_POL, 0, HS active level.
VS_POL, 0, VS active level.

Ports:
CLK  in  1  system clock (50 MHz).
RST_N  in  1  asynchronous active-low reset.
WA  in  PG_W+RA_W+CA_W  MCU address {page,row,col}. CA_W = clog2(H_ACTIVE>>SCALE_LOG2); RA_W = clog2(V_ACTIVE>>SCALE_LOG2).
WD  in  PIX_W  write data, packed {R,G,B}.
WE  in  1  write enable.
RD  out  PIX_W  registered read data at WA.
PAGE_SEL  in  PG_W  requested display page.
PAGE_ACT  out  PG_W  page currently displayed.
FRAME_START  out  1  one-CLK pulse when a page flip point occurs.
ROUT  out  R_W  red output.
GOUT  out  G_W  green output.
BOUT  out  B_W  blue output.
HS  out  1  horizontal sync.
VS  out  1  vertical sync.

Behaviour:
- Reset (async, RST_N=0):
  - Tick divider, hcnt, vcnt, pipeline registers, RD, ROUT/GOUT/BOUT and FRAME_START clear to 0; PAGE_ACT clears to 0.
  - HS=~HS_POL, VS=~VS_POL.
  - RAM contents are not cleared.
  - Reset mid-frame restarts timing at hcnt=vcnt=0 on the first tick after release.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick=1 when divider==CLK_DIV-1.
  - All display-side registers update only on tick.
- Counters:
  - hcnt wraps at H_TOTAL-1 (800); vcnt increments on hcnt wrap and wraps at V_TOTAL-1 (525).
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs_raw asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw likewise on vcnt.
- Display read address: {PAGE_ACT, vcnt[SCALE_LOG2+RA_W-1:SCALE_LOG2], hcnt[SCALE_LOG2+CA_W-1:SCALE_LOG2]}.
- Pipeline, in ticks:
  - Stage 0: counters.
  - Stage 1: synchronous RAM read, with active/hs/vs delayed one stage.
  - Stage 2: output registers.
  - Total latency is 2 ticks, identical for colour, HS and VS.
  - Colour is forced to 0 when the delayed active flag is 0.
  - HS/VS drive the active level when the delayed raw flag is 1.
- Page flip:
  - PAGE_SEL is sampled on the tick where hcnt wraps and vcnt becomes V_ACTIVE (start of vertical blank).
  - PAGE_ACT loads PAGE_SEL on that tick, and FRAME_START pulses for exactly 1 CLK.
  - PAGE_ACT never changes at any other time.
  - PAGE_SEL >= NUM_PAGES is ignored; PAGE_ACT holds its value.
- MCU port (every CLK):
  - Write when WE=1 and the address is in range.
  - Out of range means page>=NUM_PAGES, row>=V_ACTIVE>>SCALE_LOG2, or col>=H_ACTIVE>>SCALE_LOG2; such writes are dropped.
  - RD is registered with 1-CLK latency and is read-first (old data on same-address write).
  - RD=0 for an out-of-range WA.
- Port collision: a display read of an address written in the same CLK returns old data.

Decomposition:
- Package vga_fb_pkg:
  - H_TOTAL/V_TOTAL calculation functions.
  - clog2-based width functions.
  - pixel_t packed struct {r,g,b}.
  - Default 640x480@60 timing constants.
- Sub-module vga_timing_gen: divider, hcnt/vcnt, active/hs_raw/vs_raw, tick and vblank-start strobe.
- Framebuffer RAM is inferred in the top as a read-first true dual-port memory.

Test Plan:
- Reset check: hold RST_N=0 -> ROUT/GOUT/BOUT=0, HS=VS=1, PAGE_ACT=0, FRAME_START=0. Assert RST_N low mid-line -> same values immediately, with no CLK edge needed.
- Colour and first-pixel alignment:
  - Write page0 {row0,col0}=0xE3 and {row0,col1}=0x1C, then release reset.
  - Ticks 0-1 -> colour 0. Ticks 2-9 -> R=7,G=0,B=3. Tick 10 -> G=7.
  - Screen row 7 uses cell row 0; screen row 8 uses cell row 1.
- Sync timing: HS active for exactly 96 ticks (192 CLK), starting at tick 656+2 of each line. VS active for lines 490-491, aligned with HS. Line period 1600 CLK.
- Page flip:
  - Write page1 {0,0}=0x1C and set PAGE_SEL=1 at vcnt=100.
  - PAGE_ACT stays 0 until vcnt enters 480; then a single 1-CLK FRAME_START pulse.
  - Next frame pixel (0,0) -> G=7.
- Write and read-back:
  - WE with WA col=80 -> no RAM change, RD=0.
  - Valid write 0x55 to {0,5,5} -> RD shows old data the same cycle, then 0x55 one CLK later.
